// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared constants, slot state encoding and the leading-zero helper
// for the seven-segment scan controller.
// Optional feature macro used by the block: SEG_SCAN_BLINK_EN.
package seg_pkg;

    localparam int unsigned NIB_W      = 4;
    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned LZ_VEC_W   = NIB_W * MAX_DIGITS;

    // Common-anode display: a high anode enable switches the digit off.
    localparam logic ANODE_OFF = 1'b1;

    typedef logic [0:0] slot_state_t;
    localparam slot_state_t ST_GAP   = 1'b0;
    localparam slot_state_t ST_DRIVE = 1'b1;

    // 1 when digit idx and every more significant digit are zero; digit 0 never blanks.
    // Digits beyond the real display width arrive zero-extended, so they never block blanking.
    function automatic logic lz_flag(input logic [LZ_VEC_W-1:0] digits,
                                     input int unsigned          idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if ((i >= idx) && (digits[NIB_W*i +: NIB_W] != '0)) begin
                all_zero = 1'b0;
            end
        end
        return (idx != 0) && all_zero;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: datapath-side and pin-side signals of the scan controller.
//   master: drives en, lz_en, load, bcd_value (and blink_mask); observes outputs.
//   slave : the controller itself.
// blink_mask exists only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    import seg_pkg::*;

    logic                      en;
    logic                      lz_en;
    logic                      load;
    logic [NIB_W*DIGITS-1:0]   bcd_value;
    logic [NIB_W-1:0]          bcd_out;
    logic                      leading_zero;
    logic [DIGITS-1:0]         an_n;
    logic                      frame_done;
    logic                      pending;
`ifdef SEG_SCAN_BLINK_EN
    logic [DIGITS-1:0]         blink_mask;
`endif

    modport master (
        output en, lz_en, load, bcd_value,
`ifdef SEG_SCAN_BLINK_EN
        output blink_mask,
`endif
        input  bcd_out, leading_zero, an_n, frame_done, pending
    );

    modport slave (
        input  en, lz_en, load, bcd_value,
`ifdef SEG_SCAN_BLINK_EN
        input  blink_mask,
`endif
        output bcd_out, leading_zero, an_n, frame_done, pending
    );

endinterface

// File: rtl/seg_scan_ctrl_prescaler.sv
// seg_prescaler: modulo-MOD counter that advances while en=1 and holds otherwise.
//   clk, reset_n : clock and synchronous active-low reset
//   en           : count enable
//   cnt          : registered count 0..MOD-1
//   tc_c         : combinational terminal count (en and cnt == MOD-1)
module seg_prescaler #(
    parameter  int unsigned MOD = 4,
    localparam int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign tc_c = en && (cnt == LAST);

    // Wrap at the terminal count, hold while disabled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode display.
//   clk, reset_n : clock and synchronous active-low reset
//   bus (slave)  : en, lz_en, load, bcd_value in; bcd_out, leading_zero,
//                  an_n, frame_done, pending out (all registered)
// Parameters: DIGITS, SCAN_DIV (cycles per slot, >= GAP+1), GAP (blank cycles).
// Optional macro SEG_SCAN_BLINK_EN adds blink_mask and a 64-frame blink phase.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GAP      = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    seg_scan_ctrl_if.slave   bus
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = NIB_W * DIGITS;
    localparam logic [CW-1:0]     GAP_C    = CW'(GAP);
    localparam logic [DIGITS-1:0] ALL_OFF  = {DIGITS{ANODE_OFF}};

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          slot_end_c;
    logic          frame_end_c;

    // Slot prescaler, and digit index stepping once per slot.
    seg_prescaler #(.MOD(SCAN_DIV)) u_slot (
        .clk(clk), .reset_n(reset_n), .en(bus.en), .cnt(cnt), .tc_c(slot_end_c)
    );
    seg_prescaler #(.MOD(DIGITS)) u_digit (
        .clk(clk), .reset_n(reset_n), .en(slot_end_c), .cnt(idx), .tc_c(frame_end_c)
    );

    slot_state_t       st, st_nxt;
    logic [DIGITS-1:0] an_n_q, an_n_nxt;
    logic [NIB_W-1:0]  bcd_q, bcd_nxt;
    logic              lz_q, lz_nxt;
    logic              fd_q, fd_nxt;
    logic              pend_q, pend_nxt;
    logic [VW-1:0]     shadow, shadow_nxt;
    logic [VW-1:0]     disp, disp_nxt;
`ifdef SEG_SCAN_BLINK_EN
    logic [5:0]        blink_cnt, blink_cnt_nxt;
    logic              phase, phase_nxt;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st     <= ST_GAP;
            an_n_q <= ALL_OFF;
            bcd_q  <= '0;
            lz_q   <= 1'b0;
            fd_q   <= 1'b0;
            pend_q <= 1'b0;
            shadow <= '0;
            disp   <= '0;
`ifdef SEG_SCAN_BLINK_EN
            blink_cnt <= '0;
            phase     <= 1'b0;
`endif
        end else begin
            st     <= st_nxt;
            an_n_q <= an_n_nxt;
            bcd_q  <= bcd_nxt;
            lz_q   <= lz_nxt;
            fd_q   <= fd_nxt;
            pend_q <= pend_nxt;
            shadow <= shadow_nxt;
            disp   <= disp_nxt;
`ifdef SEG_SCAN_BLINK_EN
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
`endif
        end
    end

    // Slot FSM, double-buffer commit and next output values.
    always_comb begin
        st_nxt     = st;
        an_n_nxt   = an_n_q;
        bcd_nxt    = bcd_q;
        lz_nxt     = lz_q;
        fd_nxt     = 1'b0;
        pend_nxt   = pend_q;
        shadow_nxt = shadow;
        disp_nxt   = disp;
`ifdef SEG_SCAN_BLINK_EN
        blink_cnt_nxt = blink_cnt;
        phase_nxt     = phase;
`endif

        if (bus.load) begin
            shadow_nxt = bus.bcd_value;
            pend_nxt   = 1'b1;
        end

        // A load coinciding with frame end bypasses the shadow.
        if (frame_end_c) begin
            fd_nxt   = 1'b1;
            pend_nxt = 1'b0;
            if (bus.load) begin
                disp_nxt = bus.bcd_value;
            end else if (pend_q) begin
                disp_nxt = shadow;
            end
`ifdef SEG_SCAN_BLINK_EN
            blink_cnt_nxt = blink_cnt + 6'(1);
            if (blink_cnt == 6'd63) begin
                phase_nxt = ~phase;
            end
`endif
        end

        if (!bus.en) begin
            st_nxt   = ST_GAP;
            an_n_nxt = ALL_OFF;
        end else begin
            // Digit data is latched at slot start so it is stable through GAP.
            if (cnt == '0) begin
                bcd_nxt = disp[NIB_W*idx +: NIB_W];
                lz_nxt  = bus.lz_en && lz_flag(LZ_VEC_W'(disp), 32'(idx));
            end
            st_nxt = (cnt < GAP_C) ? ST_GAP : ST_DRIVE;
            case (st_nxt)
                ST_DRIVE: begin
                    an_n_nxt = ~(DIGITS'(1) << idx);
`ifdef SEG_SCAN_BLINK_EN
                    if (phase && bus.blink_mask[idx]) begin
                        an_n_nxt = ALL_OFF;
                    end
`endif
                end
                default: an_n_nxt = ALL_OFF;
            endcase
        end
    end

    assign bus.an_n         = an_n_q;
    assign bus.bcd_out      = bcd_q;
    assign bus.leading_zero = lz_q;
    assign bus.frame_done   = fd_q;
    assign bus.pending      = pend_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a DIGITS-wide common-anode seven-segment display. It shares one seven_seg decoder between all digits: each slot it presents the digit's BCD nibble and the leading-zero flag to the decoder, and drives the active-low anode enable for that digit. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the datapath (counter/clock logic producing packed BCD) and the board-level segment/anode pins.

Parameters:
DIGITS, 4, number of digits scanned; index 0 is least significant, rightmost.
SCAN_DIV, 50000, clock cycles per digit slot; must be >= GAP+1.
GAP, 2, cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  synchronous, active-low reset.
en  in  1  1 = scanning; 0 = anodes off, counters hold.
lz_en  in  1  1 = blank leading zeros.
load  in  1  one-cycle strobe; captures bcd_value.
bcd_value  in  4*DIGITS  packed BCD; nibble k is digit k.
bcd_out  out  4  nibble to the shared seven_seg decoder.
leading_zero  out  1  to the decoder; 1 = render 0 as blank.
an_n  out  DIGITS  active-low anode enables; at most one bit low.
frame_done  out  1  one-cycle pulse when the last digit slot ends.
pending  out  1  a loaded value is waiting for commit.

Behaviour:
- One clock. Reset is synchronous and active-low: clk and reset_n, sampled on the rising edge of clk.
- Reset values:
  - an_n all 1s; bcd_out 0; leading_zero 0; frame_done 0; pending 0.
  - Prescaler 0, digit index 0, shadow and display registers 0.
- Reset mid-frame aborts the frame immediately. No frame_done is issued, and any pending value is discarded.
- Prescaler counts 0..SCAN_DIV-1 while en=1.
  - At SCAN_DIV-1 it wraps to 0 and the digit index advances. The index wraps from DIGITS-1 to 0.
- Slot state machine, two states per slot:
  - GAP state: prescaler < GAP. an_n all 1s.
  - DRIVE state: an_n bit [index] = 0, all others 1.
  - bcd_out and leading_zero update at slot start, so they are stable throughout GAP.
- All outputs are registered. The values for index k appear on the cycle after the prescaler wraps into slot k.
- Leading-zero rule: leading_zero = 1 iff lz_en=1, k != 0, and display digits k..DIGITS-1 are all 0. Digit 0 is never blanked.
- Nibbles above 9 are passed through unchanged; the decoder blanks them.
- Load and commit:
  - load=1 writes bcd_value into the shadow register and sets pending.
  - A later load before commit overwrites the shadow (last write wins).
- Frame end (index DIGITS-1 and prescaler SCAN_DIV-1):
  - frame_done pulses for one cycle.
  - If pending, shadow is copied to the display register and pending clears.
- Load on the same cycle as frame end: bcd_value is committed directly to the display register, and pending is cleared.
- en=0:
  - an_n goes to all 1s on the next cycle; prescaler and index hold.
  - Loads are still accepted. No frame_done is generated.
  - Scanning resumes from the held state when en returns to 1.
- lz_en changes take effect at the next slot start.

Optional Feature:
Macro SEG_SCAN_BLINK_EN.
- Defined: adds input blink_mask [DIGITS] and a 1-bit blink phase.
  - The phase toggles every 64 frame_done pulses.
  - While the phase is 1, the anode of any digit with its blink_mask bit set stays high through DRIVE.
  - Phase resets to 0.
- Not defined: no blink_mask port, no phase register; behaviour is exactly as described above.

Decomposition:
- Shared package seg_pkg holds:
  - the nibble width constant (4);
  - the anode-off value (all 1s);
  - the slot state typedef (GAP, DRIVE);
  - a function returning the leading-zero flag for a given index and digit vector.
- One natural sub-module, seg_prescaler: counter with wrap, hold-on-disable and a terminal-count output. It can be reused for the blink divider.
- Instantiating seven_seg stays at the top level, outside this block.

Test Plan:
- Setup for all cases: SCAN_DIV=4, GAP=1, DIGITS=4.
- Reset: hold reset_n=0 for 3 cycles, release → an_n=4'b1111 on the first cycle. Slot 0 reaches DRIVE (an_n=4'b1110) within SCAN_DIV cycles. frame_done first pulses 16 cycles after release.
- Load 16'h0042, lz_en=1, wait for commit → per slot: digit0 bcd 2 lz 0; digit1 bcd 4 lz 0; digit2 bcd 0 lz 1; digit3 bcd 0 lz 1.
- Load 16'h0000, lz_en=1 → digit0 bcd 0 lz 0; digits 1–3 lz 1. With lz_en=0, all four slots show lz 0.
- Anti-tearing: commit 16'h1234, then load 16'h5678 during slot 1 → the rest of that frame shows 1234 and pending=1. After frame_done, the next frame shows 5678 and pending=0.
- Load coincident with frame end → the value is displayed from slot 0 of the next frame and pending never asserts.
- Deassert en mid-DRIVE for 10 cycles → an_n=4'b1111 from the next cycle, index unchanged. The slot resumes with the remaining prescaler count, and an_n is never more than one-hot low.
